// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Owns the single write port of the register file. Two writeback requesters,
// A (ALU) and B (load/external), share the port through round-robin
// arbitration. A clear sequencer can also zero every register, one register
// per cycle. Everything driven toward the register file is registered, so a
// transfer accepted at edge t is committed by the register file at edge t+1.
//
// Ports:
//   Clk, Reset                    clock (rising edge), async active-low reset
//   ReqA_Valid/Addr/Data, Ready   requester A handshake (transfer = Valid & Ready)
//   ReqB_Valid/Addr/Data, Ready   requester B handshake
//   ClearStart                    start a full clear; only looked at in IDLE
//   ClearBusy                     high while the clear sequence is running
//   ClearDone                     one-cycle pulse when the clear finishes
//   WriteEn, Waddr, WrData        registered write port of the register file

module regfile_write_arbiter #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int DATA_W   = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReqA_Valid,
    input  logic [ADDR_W-1:0] ReqA_Addr,
    input  logic [DATA_W-1:0] ReqA_Data,
    output logic              ReqA_Ready,
    input  logic              ReqB_Valid,
    input  logic [ADDR_W-1:0] ReqB_Addr,
    input  logic [DATA_W-1:0] ReqB_Data,
    output logic              ReqB_Ready,
    input  logic              ClearStart,
    output logic              ClearBusy,
    output logic              ClearDone,
    output logic              WriteEn,
    output logic [ADDR_W-1:0] Waddr,
    output logic [DATA_W-1:0] WrData
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    // One extra counter bit so the last index never aliases with zero when
    // NUM_REGS fills the whole address space.
    localparam logic [ADDR_W:0] LastIdx = (ADDR_W + 1)'(NUM_REGS - 1);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W:0]   counter;
    logic [ADDR_W:0]   next_counter;
    // 1 means B received the most recent grant, so A wins the next contention.
    logic              last_grant;
    logic              grant_a;
    logic              grant_b;

    // State, clear counter and round-robin pointer. The pointer only moves on
    // a real transfer, so a clear leaves it untouched.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            counter    <= '0;
            last_grant <= 1'b1;
        end else begin
            state   <= next_state;
            counter <= next_counter;
            if (grant_a || grant_b) begin
                last_grant <= grant_b;
            end
        end
    end

    // Next-state logic and combinational grants. A pending ClearStart in IDLE
    // suppresses both grants so the clear takes priority over writebacks.
    always_comb begin
        next_state   = state;
        next_counter = counter;
        grant_a      = 1'b0;
        grant_b      = 1'b0;
        case (state)
            IDLE: begin
                if (ClearStart) begin
                    next_state   = CLEAR;
                    next_counter = '0;
                end else if (ReqA_Valid && ReqB_Valid) begin
                    grant_a = last_grant;
                    grant_b = !last_grant;
                end else begin
                    grant_a = ReqA_Valid;
                    grant_b = ReqB_Valid;
                end
            end
            CLEAR: begin
                next_counter = counter + (ADDR_W + 1)'(1);
                if (counter == LastIdx) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign ReqA_Ready = grant_a;
    assign ReqB_Ready = grant_b;
    assign ClearBusy  = (state != IDLE);
    assign ClearDone  = (state == DONE);

    // Registered write port. Address and data hold when nothing is written so
    // the register file inputs only toggle on real writes.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            WriteEn <= 1'b0;
            Waddr   <= '0;
            WrData  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_a) begin
                        WriteEn <= 1'b1;
                        Waddr   <= ReqA_Addr;
                        WrData  <= ReqA_Data;
                    end else if (grant_b) begin
                        WriteEn <= 1'b1;
                        Waddr   <= ReqB_Addr;
                        WrData  <= ReqB_Data;
                    end else begin
                        WriteEn <= 1'b0;
                    end
                end
                CLEAR: begin
                    WriteEn <= 1'b1;
                    Waddr   <= counter[ADDR_W-1:0];
                    WrData  <= '0;
                end
                default: begin
                    WriteEn <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Directed bench for regfile_write_arbiter: single-requester writes,
// round-robin contention, the clear sweep (with a request and a repeated
// ClearStart during it) and a reset that aborts a clear part way through.

module tb_regfile_write_arbiter;

    logic       Clk;
    logic       Reset;
    logic       ReqA_Valid;
    logic [2:0] ReqA_Addr;
    logic [7:0] ReqA_Data;
    logic       ReqA_Ready;
    logic       ReqB_Valid;
    logic [2:0] ReqB_Addr;
    logic [7:0] ReqB_Data;
    logic       ReqB_Ready;
    logic       ClearStart;
    logic       ClearBusy;
    logic       ClearDone;
    logic       WriteEn;
    logic [2:0] Waddr;
    logic [7:0] WrData;

    int errors = 0;
    int checks = 0;

    regfile_write_arbiter dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .ReqA_Valid (ReqA_Valid),
        .ReqA_Addr  (ReqA_Addr),
        .ReqA_Data  (ReqA_Data),
        .ReqA_Ready (ReqA_Ready),
        .ReqB_Valid (ReqB_Valid),
        .ReqB_Addr  (ReqB_Addr),
        .ReqB_Data  (ReqB_Data),
        .ReqB_Ready (ReqB_Ready),
        .ClearStart (ClearStart),
        .ClearBusy  (ClearBusy),
        .ClearDone  (ClearDone),
        .WriteEn    (WriteEn),
        .Waddr      (Waddr),
        .WrData     (WrData)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Safety net so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle one unit after it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic av, input logic [2:0] aa, input logic [7:0] ad,
                                 input logic bv, input logic [2:0] ba, input logic [7:0] bd,
                                 input logic cs);
        ReqA_Valid = av;
        ReqA_Addr  = aa;
        ReqA_Data  = ad;
        ReqB_Valid = bv;
        ReqB_Addr  = ba;
        ReqB_Data  = bd;
        ClearStart = cs;
    endtask

    initial begin
        Reset = 1'b0;
        applyStimulus(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0);
        #3;
        checkOutput("rst_WriteEn",   32'(WriteEn),    0);
        checkOutput("rst_Waddr",     32'(Waddr),      0);
        checkOutput("rst_WrData",    32'(WrData),     0);
        checkOutput("rst_ReadyA",    32'(ReqA_Ready), 0);
        checkOutput("rst_ReadyB",    32'(ReqB_Ready), 0);
        checkOutput("rst_ClearBusy", 32'(ClearBusy),  0);
        checkOutput("rst_ClearDone", 32'(ClearDone),  0);
        tick();
        Reset = 1'b1;
        tick();

        // A alone: ready in the same cycle, write visible one edge later.
        applyStimulus(1, 3'd3, 8'h5A, 0, 3'd0, 8'h00, 0);
        #1;
        checkOutput("a_only_ReadyA", 32'(ReqA_Ready), 1);
        checkOutput("a_only_ReadyB", 32'(ReqB_Ready), 0);
        tick();
        applyStimulus(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0);
        checkOutput("a_only_WriteEn", 32'(WriteEn), 1);
        checkOutput("a_only_Waddr",   32'(Waddr),   3);
        checkOutput("a_only_WrData",  32'(WrData),  32'h5A);
        tick();
        checkOutput("a_only_idle_WriteEn", 32'(WriteEn), 0);
        checkOutput("a_only_hold_Waddr",   32'(Waddr),   3);
        checkOutput("a_only_hold_WrData",  32'(WrData),  32'h5A);

        // Fresh reset so contention starts from the reset pointer (A first).
        Reset = 1'b0;
        #2;
        Reset = 1'b1;
        applyStimulus(1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 0);
        #1;
        checkOutput("cont0_ReadyA", 32'(ReqA_Ready), 1);
        checkOutput("cont0_ReadyB", 32'(ReqB_Ready), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("cont_WriteEn", 32'(WriteEn), 1);
            checkOutput("cont_Waddr",   32'(Waddr),  (i % 2 == 0) ? 1 : 2);
            checkOutput("cont_WrData",  32'(WrData), (i % 2 == 0) ? 32'h11 : 32'h22);
            checkOutput("cont_ReadyA",  32'(ReqA_Ready), (i % 2 == 0) ? 0 : 1);
            checkOutput("cont_ReadyB",  32'(ReqB_Ready), (i % 2 == 0) ? 1 : 0);
        end
        // Requests withdrawn before the edge: nothing transfers, pointer stays B.
        applyStimulus(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0);
        tick();
        checkOutput("cont_end_WriteEn", 32'(WriteEn), 0);

        // ClearStart together with a B request: clear wins, B waits.
        applyStimulus(0, 3'd0, 8'h00, 1, 3'd5, 8'h77, 1);
        #1;
        checkOutput("clr_req_ReadyB", 32'(ReqB_Ready), 0);
        checkOutput("clr_req_ReadyA", 32'(ReqA_Ready), 0);
        checkOutput("clr_req_Busy0",  32'(ClearBusy),  0);
        tick();
        ClearStart = 1'b0;
        checkOutput("clr_Busy",       32'(ClearBusy),  1);
        checkOutput("clr_WriteEn0",   32'(WriteEn),    0);
        checkOutput("clr_ReadyB0",    32'(ReqB_Ready), 0);
        for (int i = 0; i < 8; i++) begin
            // Re-asserting ClearStart mid-sweep must have no effect.
            ClearStart = (i == 3 || i == 4);
            tick();
            checkOutput("clr_WriteEn", 32'(WriteEn),    1);
            checkOutput("clr_Waddr",   32'(Waddr),      i);
            checkOutput("clr_WrData",  32'(WrData),     0);
            checkOutput("clr_ReadyB",  32'(ReqB_Ready), 0);
            checkOutput("clr_Busy_i",  32'(ClearBusy),  1);
            checkOutput("clr_Done",    32'(ClearDone),  (i == 7) ? 1 : 0);
        end
        ClearStart = 1'b0;
        tick();
        checkOutput("post_clr_Done",    32'(ClearDone),  0);
        checkOutput("post_clr_Busy",    32'(ClearBusy),  0);
        checkOutput("post_clr_WriteEn", 32'(WriteEn),    0);
        checkOutput("post_clr_ReadyB",  32'(ReqB_Ready), 1);
        tick();
        applyStimulus(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0);
        checkOutput("b_after_clr_WriteEn", 32'(WriteEn), 1);
        checkOutput("b_after_clr_Waddr",   32'(Waddr),   5);
        checkOutput("b_after_clr_WrData",  32'(WrData),  32'h77);
        tick();
        checkOutput("b_after_clr_idle", 32'(WriteEn), 0);

        // Reset asserted right after the Waddr=2 clear write.
        ClearStart = 1'b1;
        tick();
        ClearStart = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("abort_pre_Waddr",   32'(Waddr),   2);
        checkOutput("abort_pre_WriteEn", 32'(WriteEn), 1);
        Reset = 1'b0;
        #1;
        checkOutput("abort_WriteEn", 32'(WriteEn),   0);
        checkOutput("abort_Waddr",   32'(Waddr),     0);
        checkOutput("abort_Busy",    32'(ClearBusy), 0);
        checkOutput("abort_Done",    32'(ClearDone), 0);
        tick();
        checkOutput("abort_held_Done", 32'(ClearDone), 0);
        Reset = 1'b1;
        applyStimulus(1, 3'd6, 8'h3C, 0, 3'd0, 8'h00, 0);
        #1;
        checkOutput("abort_a_ReadyA", 32'(ReqA_Ready), 1);
        tick();
        applyStimulus(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0);
        checkOutput("abort_a_WriteEn", 32'(WriteEn),   1);
        checkOutput("abort_a_Waddr",   32'(Waddr),     6);
        checkOutput("abort_a_WrData",  32'(WrData),    32'h3C);
        checkOutput("abort_a_Busy",    32'(ClearBusy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
